// File: rtl/noc_input_port.sv
// noc_input_port: per-port ingress stage for the round-robin crossbar.
// Buffers incoming flits in a FIFO, latches the destination from each head
// flit and holds one crossbar request per packet until PKT_LEN flits pop.
module noc_input_port #(
    parameter int unsigned PORTS   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PKT_LEN = 4,
    localparam int unsigned DEST_W = $clog2(PORTS),
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  xb_data,
    output logic [DEST_W-1:0] xb_dest,
    output logic              xb_dest_en,
    input  logic              xb_ack,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DEST_W-1:0] dest_q;
    state_e            state_q;
    logic              push;
    logic              pop;

    // Handshake and request outputs, all derived from registered state only
    always_comb begin
        in_ready   = (occ_q != OCC_W'(DEPTH));
        xb_dest_en = (state_q == SEND) && (occ_q != '0);
        push       = in_valid && in_ready;
        pop        = xb_ack && xb_dest_en;
        xb_data    = mem_q[rptr_q];
        xb_dest    = dest_q;
        occupancy  = occ_q;
    end

    // Next-state for FIFO pointers and occupancy; pointers wrap naturally
    always_comb begin
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Packet FSM: latch destination from the head flit, count pops per packet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (occ_q != '0) begin
                        dest_q  <= mem_q[rptr_q][WIDTH-1 -: DEST_W];
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Testbench for noc_input_port (PORTS=4, WIDTH=8, DEPTH=4, PKT_LEN=4).
// A queue-based packet model predicts request, occupancy and data per cycle.
module tb_noc_input_port;

    localparam int PKT_LEN = 4;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] xb_data;
    logic [1:0] xb_dest;
    logic       xb_dest_en;
    logic       xb_ack;
    logic [2:0] occupancy;

    int checks;
    int errors;

    noc_input_port #(
        .PORTS  (4),
        .WIDTH  (8),
        .DEPTH  (DEPTH),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xb_data   (xb_data),
        .xb_dest   (xb_dest),
        .xb_dest_en(xb_dest_en),
        .xb_ack    (xb_ack),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flit queue plus "packet open" bookkeeping
    logic [7:0] mq[$];
    bit         m_send;
    logic [1:0] m_dest;
    int         m_sent;
    logic [7:0] m_mem[DEPTH];
    int         m_wp;

    function automatic bit m_en();
        return m_send && (mq.size() > 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_send = 0;
        m_dest = 2'd0;
        m_sent = 0;
        m_wp   = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit a);
        bit push;
        bit pop;
        push = v && (mq.size() < DEPTH);
        pop  = a && m_en();
        if (!m_send) begin
            if (mq.size() > 0) begin
                m_send = 1;
                m_dest = mq[0][7:6];
                m_sent = 0;
            end
        end else if (pop) begin
            m_sent++;
            if (m_sent == PKT_LEN) m_send = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(d);
            m_mem[m_wp] = d;
            m_wp = (m_wp + 1) % DEPTH;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit a);
        in_valid = v;
        in_data  = d;
        xb_ack   = a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(in_valid, in_data, xb_ack);
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 8'h00, 1);
        for (int i = 0; i < 40 && (m_send || mq.size() > 0); i++) tick();
        drive(0, 8'h00, 0);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
        checks++; if (xb_dest_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b exp 0", xb_dest_en); end
        checks++; if (xb_dest !== 2'd0) begin errors++; $display("FAIL reset_dest got %0d exp 0", xb_dest); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_single_packet();
        logic [7:0] pat[4];
        logic [7:0] got[$];
        int first;
        int last;
        pat = '{8'hC1, 8'h02, 8'h03, 8'h04};
        first = -1;
        last  = -1;
        for (int c = 0; c < 12; c++) begin
            drive(c < 4, pat[c % 4], 1);
            if (xb_dest_en === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    checks++; if (xb_dest !== 2'd3) begin errors++; $display("FAIL single_dest got %0d exp 3", xb_dest); end
                end
                got.push_back(xb_data);
                last = c;
            end
            tick();
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", first); end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== pat[i]) begin errors++; $display("FAIL single_data[%0d] got %0h exp %0h", i, got[i], pat[i]); end
        end
        checks++; if (last - first !== 3) begin errors++; $display("FAIL single_contig got %0d exp 3", last - first); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_full_fifo();
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'h10 + 8'(c), 0);
            tick();
            if (c == 3) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", in_ready); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
            end
        end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_fifth got %0d exp 4", occupancy); end
        drive(0, 8'h00, 1);
        tick();
        drive(0, 8'h00, 0);
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL full_pop_occ got %0d exp 3", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %0b exp 1", in_ready); end
        checks++; if (xb_data !== 8'h11) begin errors++; $display("FAIL full_next got %0h exp 11", xb_data); end
        drain();
        checks++; if (occupancy !== 3'd0 || xb_dest_en !== 1'b0) begin errors++; $display("FAIL full_drain got occ %0d en %0b exp 0 0", occupancy, xb_dest_en); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stim[8];
        bit         ens[$];
        logic [1:0] ds[$];
        logic [7:0] dat[$];
        bit         started;
        int         k;
        started = 0;
        for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
        stim[0] = 8'h40;
        stim[4] = 8'h80;
        for (int c = 0; c < 21; c++) begin
            drive(c < 8, stim[c % 8], 1);
            if (xb_dest_en === 1'b1) started = 1;
            if (started) begin
                ens.push_back(xb_dest_en === 1'b1);
                ds.push_back(xb_dest);
                if (xb_dest_en === 1'b1) dat.push_back(xb_data);
            end
            tick();
        end
        checks++; if (ens.size() < 10) begin errors++; $display("FAIL b2b_len got %0d exp >=10", ens.size()); end
        for (int i = 0; i < 10 && i < ens.size(); i++) begin
            bit exp_en;
            logic [1:0] exp_d;
            exp_en = (i != 4) && (i != 9);
            exp_d  = (i < 4) ? 2'd1 : 2'd2;
            checks++; if (ens[i] !== exp_en) begin errors++; $display("FAIL b2b_en[%0d] got %0b exp %0b", i, ens[i], exp_en); end
            if (exp_en) begin
                checks++; if (ds[i] !== exp_d) begin errors++; $display("FAIL b2b_dest[%0d] got %0d exp %0d", i, ds[i], exp_d); end
            end
        end
        k = (dat.size() < 8) ? dat.size() : 8;
        checks++; if (dat.size() !== 8) begin errors++; $display("FAIL b2b_pops got %0d exp 8", dat.size()); end
        for (int i = 0; i < k; i++) begin
            checks++; if (dat[i] !== stim[i]) begin errors++; $display("FAIL b2b_data[%0d] got %0h exp %0h", i, dat[i], stim[i]); end
        end
    endtask

    task automatic test_bubble();
        logic [7:0] seq[7];
        bit         vld[7];
        logic [7:0] dat[$];
        int first;
        int last;
        int gaps;
        seq = '{8'hC5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h0C};
        vld = '{1, 1, 0, 0, 0, 1, 1};
        first = -1;
        last  = -1;
        gaps  = 0;
        for (int c = 0; c < 15; c++) begin
            drive((c < 7) ? vld[c % 7] : 1'b0, seq[c % 7], 1);
            if (xb_dest_en === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                dat.push_back(xb_data);
                checks++; if (xb_dest !== 2'd3) begin errors++; $display("FAIL bubble_dest c%0d got %0d exp 3", c, xb_dest); end
            end else if (first >= 0 && m_send) begin
                gaps++;
                checks++; if (xb_dest !== 2'd3) begin errors++; $display("FAIL bubble_hold c%0d got %0d exp 3", c, xb_dest); end
            end
            tick();
        end
        checks++; if (dat.size() !== 4) begin errors++; $display("FAIL bubble_pops got %0d exp 4", dat.size()); end
        checks++; if (gaps !== 2) begin errors++; $display("FAIL bubble_gap got %0d exp 2", gaps); end
        checks++; if (last - first !== 5) begin errors++; $display("FAIL bubble_span got %0d exp 5", last - first); end
        if (dat.size() == 4) begin
            checks++; if (dat[2] !== 8'h0B || dat[3] !== 8'h0C) begin errors++; $display("FAIL bubble_data got %0h %0h exp 0b 0c", dat[2], dat[3]); end
        end
    endtask

    task automatic test_stalled_ack();
        logic [7:0] head;
        logic [7:0] h2;
        head = 8'($urandom_range(0, 255));
        h2   = 8'($urandom_range(0, 255));
        for (int c = 0; c < 4; c++) begin
            drive(1, (c == 0) ? head : 8'($urandom_range(0, 255)), 0);
            tick();
        end
        drive(0, 8'h00, 0);
        for (int c = 0; c < 5; c++) begin
            checks++; if (xb_dest_en !== 1'b1 || xb_data !== head || xb_dest !== head[7:6] || occupancy !== 3'd4) begin
                errors++;
                $display("FAIL stall c%0d got en %0b data %0h dest %0d occ %0d exp 1 %0h %0d 4",
                         c, xb_dest_en, xb_data, xb_dest, occupancy, head, head[7:6]);
            end
            tick();
        end
        drain();
        drive(1, h2, 0);
        tick();
        drive(0, 8'h00, 1);
        checks++; if (xb_dest_en !== 1'b0) begin errors++; $display("FAIL idle_ack_en got %0b exp 0", xb_dest_en); end
        tick();
        drive(0, 8'h00, 0);
        checks++; if (occupancy !== 3'd1 || xb_data !== h2) begin errors++; $display("FAIL idle_ack_pop got occ %0d data %0h exp 1 %0h", occupancy, xb_data, h2); end
        checks++; if (xb_dest_en !== 1'b1 || xb_dest !== h2[7:6]) begin errors++; $display("FAIL idle_ack_req got en %0b dest %0d exp 1 %0d", xb_dest_en, xb_dest, h2[7:6]); end
        for (int c = 0; c < 3; c++) begin
            drive(1, 8'($urandom_range(0, 255)), 0);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_packet();
        bit seen;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1, (c == 0) ? 8'h40 : 8'($urandom_range(0, 255)), 1);
            tick();
        end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL rstmid_pre_occ got %0d exp 2", occupancy); end
        drive(0, 8'h00, 0);
        rst = 1'b0;
        #1;
        checks++; if (xb_dest_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctl got en %0b rdy %0b exp 0 1", xb_dest_en, in_ready); end
        checks++; if (occupancy !== 3'd0 || xb_dest !== 2'd0) begin errors++; $display("FAIL rstmid_state got occ %0d dest %0d exp 0 0", occupancy, xb_dest); end
        checks++; if (xb_data !== m_mem[0]) begin errors++; $display("FAIL rstmid_data got %0h exp %0h", xb_data, m_mem[0]); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            drive(c < 4, (c == 0) ? 8'h80 : 8'($urandom_range(0, 63)), 1);
            if (xb_dest_en === 1'b1 && !seen) begin
                seen = 1;
                checks++; if (xb_dest !== 2'd2 || xb_data !== 8'h80) begin errors++; $display("FAIL rstmid_head got dest %0d data %0h exp 2 80", xb_dest, xb_data); end
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_timeout got no request exp request"); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            checks++; if (xb_dest_en !== m_en()) begin errors++; $display("FAIL rand_en c%0d got %0b exp %0b", c, xb_dest_en, m_en()); end
            checks++; if (occupancy !== 3'(mq.size())) begin errors++; $display("FAIL rand_occ c%0d got %0d exp %0d", c, occupancy, mq.size()); end
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_ready c%0d got %0b exp %0b", c, in_ready, mq.size() < DEPTH); end
            if (m_en()) begin
                checks++; if (xb_data !== mq[0]) begin errors++; $display("FAIL rand_data c%0d got %0h exp %0h", c, xb_data, mq[0]); end
                checks++; if (xb_dest !== m_dest) begin errors++; $display("FAIL rand_dest c%0d got %0d exp %0d", c, xb_dest, m_dest); end
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        xb_ack   = 1'b0;
        model_reset();
        test_reset();
        test_single_packet();
        test_full_fifo();
        test_back_to_back();
        test_bubble();
        test_stalled_ack();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Per-port ingress stage for the round-robin crossbar. Accepts fixed-length packets from a link over a valid/ready handshake and buffers the flits in a FIFO. Decodes the destination port from each head flit and drives the crossbar request lines (data, dest, dest_en) for that port, popping one flit for every crossbar ack. Destination and request stay stable for the whole packet, so the crossbar sees one uninterrupted request per packet, apart from bubbles when the FIFO runs empty.

## Interface
Parameters:
- PORTS, 4, number of crossbar ports; DEST_W = $clog2(PORTS)
- WIDTH, 8, flit width in bits; must be > DEST_W
- DEPTH, 4, FIFO depth in flits; power of two, ≥ 2
- PKT_LEN, 4, flits per packet including head; ≥ 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst = 0 resets)
- in_data  in  WIDTH  incoming flit
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept a flit; = !full
- xb_data  out  WIDTH  flit at FIFO head, to crossbar data_i
- xb_dest  out  DEST_W  latched destination, to crossbar dest
- xb_dest_en  out  1  request valid, to crossbar dest_en
- xb_ack  in  1  crossbar consumed the presented flit this cycle
- occupancy  out  $clog2(DEPTH+1)  flits currently stored

## Operation
- Push: when in_valid && in_ready at a rising edge, in_data is written at the write pointer. The pointer wraps modulo DEPTH.
- Pop: when xb_ack && xb_dest_en at a rising edge, the read pointer advances (wraps modulo DEPTH) and the flit counter increments.
  - xb_ack while xb_dest_en = 0 is ignored.
- Occupancy: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop is legal at any occupancy below DEPTH.
  - When full, in_ready = 0, so no push occurs even if a pop happens in the same cycle.
- Head flit: the first flit of each packet. The first flit after reset is a head; thereafter every flit following the PKT_LEN-th flit of a packet is a head.
  - Destination field = head flit bits [WIDTH-1 -: DEST_W].
  - The full head flit, including that field, is forwarded unchanged.
- State machine, 2 states:
  - IDLE: xb_dest_en = 0, flit counter = 0. If occupancy ≠ 0 at a rising edge, latch xb_dest from the destination field of the FIFO-head flit and go to SEND.
  - SEND: xb_dest_en = (occupancy ≠ 0). xb_dest is held constant.
    - On each pop, the counter increments.
    - A pop while counter = PKT_LEN−1 returns the state to IDLE and clears the counter.
    - FIFO empty mid-packet: xb_dest_en drops to 0, state stays SEND, and the request resumes with the same xb_dest when data arrives.
- xb_data always shows the FIFO-head entry, combinationally from the read pointer. It is don't-care when xb_dest_en = 0.
- No error detection: packets are assumed well-formed by length.

## Timing
- Reset values (asynchronous, while rst = 0):
  - state IDLE, pointers 0, counter 0, occupancy 0
  - in_ready 1, xb_dest_en 0, xb_dest 0
  - xb_data: value of entry 0, storage not cleared
- Reset mid-packet discards all buffered and partial flits. The first flit accepted after reset is treated as a head.
- Minimum latency: a flit pushed at edge E0 makes the state SEND at E1, with xb_dest_en = 1 after E1. That is 1 cycle of IDLE plus 1 cycle to request.
- Back-to-back within a packet: with continuous acks and a non-empty FIFO, one flit pops per cycle.
- Between packets: exactly one IDLE cycle, with xb_dest_en = 0, follows the last pop of a packet. This gives the crossbar a release point for re-arbitration.
- xb_dest, xb_dest_en and in_ready are register-derived. None depends combinationally on in_valid or xb_ack.

## Test plan
- Single packet: with PKT_LEN = 4, push 0xC1, 0x02, 0x03, 0x04 on consecutive cycles with xb_ack held at 1.
  - Required: xb_dest = 3 from the first SEND cycle.
  - xb_data sequence 0xC1, 0x02, 0x03, 0x04 on 4 consecutive request cycles.
  - Then 1 IDLE cycle and occupancy 0.
- Full FIFO: push 5 flits with xb_ack = 0.
  - Required: in_ready = 0 after the 4th push, occupancy = 4, 5th flit not accepted.
  - Raise xb_ack for 1 cycle: occupancy = 3, in_ready = 1.
- Back-to-back packets: push heads 0x40 (dest 1) and 0x80 (dest 2), each followed by 3 body flits, with xb_ack = 1.
  - Required: xb_dest 1 for 4 pops, then exactly 1 cycle with xb_dest_en = 0, then xb_dest 2 for 4 pops.
- Mid-packet bubble: push the head and 1 body flit, stall the input 3 cycles, then push 2 more.
  - Required: xb_dest_en = 0 during the stall, state stays SEND, xb_dest unchanged.
  - Exactly 4 pops total before IDLE.
- Stalled ack: present a packet and hold xb_ack = 0 for 5 cycles.
  - Required: xb_data, xb_dest and xb_dest_en stable throughout, no pop.
  - xb_ack pulsed while in IDLE causes no pop.
- Reset mid-packet: assert rst = 0 after 2 of 4 flits have been popped, with 2 flits buffered.
  - Required: outputs go to reset values immediately.
  - After release, the next pushed flit 0x80 is treated as a head (xb_dest = 2).
